sap1_ctrl_seq: RTL and testbench

- SAP-1 controller-sequencer. It is the initiator side of the register LOAD/ENABLE interface: it issues every load (L*) and bus-enable (E*) strobe that the buffer registers, PC, MAR, RAM and ALU respond to.
- A one-hot 6-state ring counter (T1..T6) is decoded together with the instruction-register opcode into the SAP-1 control word.
- All strobes are active-high and match the LOAD/ENABLE polarity of the registers.

---
 rtl/sap1_ctrl_pkg.sv | 47 ++++
 rtl/sap1_ring_counter.sv | 39 +++
 rtl/sap1_ctrl_seq.sv | 150 +++++++++++++++
 tb/tb_sap1_ctrl_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sap1_ctrl_pkg.sv
// rtl/sap1_ctrl_pkg.sv - SAP-1 controller opcodes, T-state indices and control word type
package sap1_ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int N_TSTATES = 6;

    // Bit index of each T-state inside the one-hot ring
    localparam logic [2:0] T1 = 3'd0;
    localparam logic [2:0] T2 = 3'd1;
    localparam logic [2:0] T3 = 3'd2;
    localparam logic [2:0] T4 = 3'd3;
    localparam logic [2:0] T5 = 3'd4;
    localparam logic [2:0] T6 = 3'd5;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_word_t;

    // One-hot ring to T-state index; the ring guarantees a single set bit
    function automatic logic [2:0] tstate_idx(input logic [N_TSTATES-1:0] onehot);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < N_TSTATES; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// rtl/sap1_ring_counter.sv - one-hot T-state ring with async clear, hold and restart
module sap1_ring_counter #(
    parameter int N = 6
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         hold_i,
    input  logic         restart_i,
    output logic [N-1:0] tstate_o
);

    logic [N-1:0] tstate_q;
    logic [N-1:0] tstate_d;

    // Next ring state: hold wins over restart, restart wins over rotation
    always_comb begin
        tstate_d = tstate_q;
        if (hold_i) begin
            tstate_d = tstate_q;
        end else if (restart_i) begin
            tstate_d    = '0;
            tstate_d[0] = 1'b1;
        end else begin
            tstate_d = {tstate_q[N-2:0], tstate_q[N-1]};
        end
    end

    // Ring register, cleared to T1 asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tstate_q <= {{(N-1){1'b0}}, 1'b1};
        end else begin
            tstate_q <= tstate_d;
        end
    end

    assign tstate_o = tstate_q;

endmodule

// File: rtl/sap1_ctrl_seq.sv
// rtl/sap1_ctrl_seq.sv - SAP-1 controller-sequencer; SAP1_CTRL_EARLY_EXIT_EN enables variable-length machine cycles
module sap1_ctrl_seq
    import sap1_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int T_STATES = 6
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic [OPCODE_W-1:0] OPCODE,
    output logic                CP,
    output logic                EP,
    output logic                LM,
    output logic                CE,
    output logic                LI,
    output logic                EI,
    output logic                LA,
    output logic                EA,
    output logic                SU,
    output logic                EU,
    output logic                LB,
    output logic                LO,
    output logic                HLT,
    output logic [T_STATES-1:0] TSTATE
);

    if (T_STATES != 6) begin : g_bad_t_states
        $error("sap1_ctrl_seq: T_STATES must be 6");
    end

    logic [T_STATES-1:0] tstate;
    logic [2:0]          t_idx;
    logic                is_lda;
    logic                is_add;
    logic                is_sub;
    logic                is_out;
    logic                is_hlt;
    logic                halt_now;
    logic                halt_q;
    logic                halt_d;
    logic                restart;
    ctrl_word_t          ctrl_dec;
    ctrl_word_t          ctrl;

    assign is_lda = (OPCODE == OP_LDA);
    assign is_add = (OPCODE == OP_ADD);
    assign is_sub = (OPCODE == OP_SUB);
    assign is_out = (OPCODE == OP_OUT);
    assign is_hlt = (OPCODE == OP_HLT);

    // HLT takes effect in T4 itself; the flag then keeps the ring frozen there
    assign halt_now = tstate[T4] & is_hlt;
    assign halt_d   = halt_q | halt_now;

`ifdef SAP1_CTRL_EARLY_EXIT_EN
    logic is_nop;
    assign is_nop  = ~(is_lda | is_add | is_sub | is_out | is_hlt);
    assign restart = (tstate[T5] & is_lda) | (tstate[T4] & (is_out | is_nop));
`else
    assign restart = 1'b0;
`endif

    sap1_ring_counter #(
        .N (T_STATES)
    ) u_ring (
        .clk_i     (CLK),
        .rst_ni    (CLR),
        .hold_i    (halt_d),
        .restart_i (restart),
        .tstate_o  (tstate)
    );

    // Sticky halt flag, only cleared by CLR
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign t_idx = tstate_idx(tstate);

    // Control word decode from T-state and opcode; opcode only matters in T4..T6
    always_comb begin
        ctrl_dec = '0;
        if (!halt_q) begin
            case (t_idx)
                T1: begin
                    ctrl_dec.ep = 1'b1;
                    ctrl_dec.lm = 1'b1;
                end
                T2: begin
                    ctrl_dec.cp = 1'b1;
                end
                T3: begin
                    ctrl_dec.ce = 1'b1;
                    ctrl_dec.li = 1'b1;
                end
                T4: begin
                    if (is_lda | is_add | is_sub) begin
                        ctrl_dec.ei = 1'b1;
                        ctrl_dec.lm = 1'b1;
                    end else if (is_out) begin
                        ctrl_dec.ea = 1'b1;
                        ctrl_dec.lo = 1'b1;
                    end
                end
                T5: begin
                    if (is_lda) begin
                        ctrl_dec.ce = 1'b1;
                        ctrl_dec.la = 1'b1;
                    end else if (is_add | is_sub) begin
                        ctrl_dec.ce = 1'b1;
                        ctrl_dec.lb = 1'b1;
                    end
                end
                T6: begin
                    if (is_add | is_sub) begin
                        ctrl_dec.eu = 1'b1;
                        ctrl_dec.la = 1'b1;
                        ctrl_dec.su = is_sub;
                    end
                end
                default: begin
                    ctrl_dec = '0;
                end
            endcase
        end
    end

    // CLR low overrides the T1 decode so every strobe is dead during reset
    assign ctrl = CLR ? ctrl_dec : '0;

    assign CP     = ctrl.cp;
    assign EP     = ctrl.ep;
    assign LM     = ctrl.lm;
    assign CE     = ctrl.ce;
    assign LI     = ctrl.li;
    assign EI     = ctrl.ei;
    assign LA     = ctrl.la;
    assign EA     = ctrl.ea;
    assign SU     = ctrl.su;
    assign EU     = ctrl.eu;
    assign LB     = ctrl.lb;
    assign LO     = ctrl.lo;
    assign HLT    = CLR & (halt_q | halt_now);
    assign TSTATE = tstate;

endmodule

// File: tb/tb_sap1_ctrl_seq.sv
// tb/tb_sap1_ctrl_seq.sv - directed self-checking bench for sap1_ctrl_seq
module tb_sap1_ctrl_seq;

    localparam logic [11:0] B_CP = 12'h800;
    localparam logic [11:0] B_EP = 12'h400;
    localparam logic [11:0] B_LM = 12'h200;
    localparam logic [11:0] B_CE = 12'h100;
    localparam logic [11:0] B_LI = 12'h080;
    localparam logic [11:0] B_EI = 12'h040;
    localparam logic [11:0] B_LA = 12'h020;
    localparam logic [11:0] B_EA = 12'h010;
    localparam logic [11:0] B_SU = 12'h008;
    localparam logic [11:0] B_EU = 12'h004;
    localparam logic [11:0] B_LB = 12'h002;
    localparam logic [11:0] B_LO = 12'h001;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [3:0]  OPCODE;
    logic        CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO, HLT;
    logic [5:0]  TSTATE;
    logic [11:0] cw;

    int n_checks = 0;
    int n_pass   = 0;

    sap1_ctrl_seq dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .OPCODE (OPCODE),
        .CP     (CP),
        .EP     (EP),
        .LM     (LM),
        .CE     (CE),
        .LI     (LI),
        .EI     (EI),
        .LA     (LA),
        .EA     (EA),
        .SU     (SU),
        .EU     (EU),
        .LB     (LB),
        .LO     (LO),
        .HLT    (HLT),
        .TSTATE (TSTATE)
    );

    assign cw = {CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO};

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Expected control word for T-state index t (0 = T1)
    function automatic logic [11:0] exp_cw(input logic [3:0] op, input int t);
        logic [11:0] w;
        w = 12'h000;
        case (t)
            0: w = B_EP | B_LM;
            1: w = B_CP;
            2: w = B_CE | B_LI;
            3: begin
                if (op == 4'b0000 || op == 4'b0001 || op == 4'b0010) w = B_EI | B_LM;
                else if (op == 4'b1110) w = B_EA | B_LO;
            end
            4: begin
                if (op == 4'b0000) w = B_CE | B_LA;
                else if (op == 4'b0001 || op == 4'b0010) w = B_CE | B_LB;
            end
            5: begin
                if (op == 4'b0001) w = B_EU | B_LA;
                else if (op == 4'b0010) w = B_EU | B_LA | B_SU;
            end
            default: w = 12'h000;
        endcase
        return w;
    endfunction

    function automatic int exp_len(input logic [3:0] op);
`ifdef SAP1_CTRL_EARLY_EXIT_EN
        if (op == 4'b0000) return 5;
        if (op == 4'b0001 || op == 4'b0010) return 6;
        return 4;
`else
        return (op == 4'b1111) ? 4 : 6;
`endif
    endfunction

    // Runs one full non-halting instruction starting at a T1 sample point;
    // junk opcode (HLT) is driven during T1..T2 to show fetch ignores it
    task automatic run_instr(input logic [3:0] op, input string name);
        int len;
        len = exp_len(op);
        OPCODE = 4'hF;
        for (int t = 0; t < len; t++) begin
            if (t == 2) OPCODE = op;
            #1;
            chk($sformatf("%s T%0d tstate", name, t + 1), 32'(TSTATE), 32'(1) << t);
            chk($sformatf("%s T%0d cw", name, t + 1), 32'(cw), 32'(exp_cw(op, t)));
            chk($sformatf("%s T%0d hlt", name, t + 1), 32'(HLT), 32'd0);
            step();
        end
        chk($sformatf("%s next T1", name), 32'(TSTATE), 32'd1);
    endtask

    // Bus exclusivity on every cycle
    always @(negedge CLK) begin
        chk("bus_excl", 32'($countones({EP, CE, EI, EA, EU}) <= 1), 32'd1);
    end

    initial begin
        CLR    = 1'b0;
        OPCODE = 4'b0000;

        repeat (3) begin
            step();
            chk("rst cw", 32'(cw), 32'd0);
            chk("rst tstate", 32'(TSTATE), 32'd1);
            chk("rst hlt", 32'(HLT), 32'd0);
        end
        CLR = 1'b1;

        run_instr(4'b0000, "LDA");
        run_instr(4'b0001, "ADD");
        run_instr(4'b0010, "SUB");
        run_instr(4'b1110, "OUT");
        run_instr(4'b0111, "NOP");

        // ADD aborted by CLR during T5
        OPCODE = 4'hF;
        for (int t = 0; t < 4; t++) begin
            if (t == 2) OPCODE = 4'b0001;
            #1;
            chk($sformatf("abort T%0d cw", t + 1), 32'(cw), 32'(exp_cw(4'b0001, t)));
            step();
        end
        #1;
        chk("abort T5 cw", 32'(cw), 32'(B_CE | B_LB));
        chk("abort T5 tstate", 32'(TSTATE), 32'h10);
        CLR = 1'b0;
        #1;
        chk("abort clr cw", 32'(cw), 32'd0);
        chk("abort clr tstate", 32'(TSTATE), 32'd1);
        step();
        chk("abort held cw", 32'(cw), 32'd0);
        chk("abort held tstate", 32'(TSTATE), 32'd1);
        CLR = 1'b1;
        #1;
        chk("abort release cw", 32'(cw), 32'(B_EP | B_LM));
        chk("abort release tstate", 32'(TSTATE), 32'd1);
        run_instr(4'b1110, "OUT2");

        // HLT freezes at T4
        OPCODE = 4'hF;
        for (int t = 0; t < 3; t++) begin
            #1;
            chk($sformatf("HLT T%0d cw", t + 1), 32'(cw), 32'(exp_cw(4'hF, t)));
            chk($sformatf("HLT T%0d hlt", t + 1), 32'(HLT), 32'd0);
            step();
        end
        #1;
        chk("HLT T4 tstate", 32'(TSTATE), 32'h08);
        chk("HLT T4 hlt", 32'(HLT), 32'd1);
        chk("HLT T4 cw", 32'(cw), 32'd0);
        repeat (20) begin
            step();
            chk("halted tstate", 32'(TSTATE), 32'h08);
            chk("halted cp", 32'(CP), 32'd0);
            chk("halted cw", 32'(cw), 32'd0);
            chk("halted hlt", 32'(HLT), 32'd1);
        end
        CLR = 1'b0;
        #1;
        chk("unhalt clr hlt", 32'(HLT), 32'd0);
        chk("unhalt clr tstate", 32'(TSTATE), 32'd1);
        chk("unhalt clr cw", 32'(cw), 32'd0);
        step();
        CLR = 1'b1;
        #1;
        chk("unhalt release cw", 32'(cw), 32'(B_EP | B_LM));
        chk("unhalt release hlt", 32'(HLT), 32'd0);
        run_instr(4'b0000, "LDA2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
